// File: rtl/regfile_wb_scheduler.sv
// Register file write-port arbiter for the ALU and load/store writeback paths.
// Also keeps the busy-register scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_REGS  = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_issue_valid,
  input  logic              i_issue_we,
  input  logic [ADDR_W-1:0] i_issue_rd,
  input  logic [ADDR_W-1:0] i_issue_rs1,
  input  logic [ADDR_W-1:0] i_issue_rs2,
  output logic              o_issue_stall,
  input  logic              i_wb0_valid,
  input  logic [ADDR_W-1:0] i_wb0_addr,
  input  logic [DATA_W-1:0] i_wb0_data,
  output logic              o_wb0_ready,
  input  logic              i_wb1_valid,
  input  logic [ADDR_W-1:0] i_wb1_addr,
  input  logic [DATA_W-1:0] i_wb1_data,
  output logic              o_wb1_ready,
  output logic                o_reg_write,
  output logic [ADDR_W-1:0]   o_addr_des,
  output logic [DATA_W-1:0]   o_data,
  output logic [NUM_REGS-1:0] o_busy
);

  logic                rr_ptr;
  logic                gnt0;
  logic                gnt1;
  logic                xfer;
  logic                wr_live;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                issue_fire;
  logic [NUM_REGS-1:0] busy_nxt;

  // Grant: a lone requester always wins; on contention use mode rule.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (i_wb0_valid && i_wb1_valid) begin
      if (PRIO_MODE != 0) begin
        gnt1 = 1'b1;
      end else if (rr_ptr) begin
        gnt1 = 1'b1;
      end else begin
        gnt0 = 1'b1;
      end
    end else begin
      gnt0 = i_wb0_valid;
      gnt1 = i_wb1_valid;
    end
  end

  assign o_wb0_ready = gnt0;
  assign o_wb1_ready = gnt1;
  assign xfer        = gnt0 | gnt1;
  assign sel_addr    = gnt1 ? i_wb1_addr : i_wb0_addr;
  assign sel_data    = gnt1 ? i_wb1_data : i_wb0_data;
  assign wr_live     = xfer && (sel_addr != '0);

  assign o_issue_stall = i_issue_valid &&
                         (o_busy[i_issue_rs1] ||
                          o_busy[i_issue_rs2] ||
                          (i_issue_we && o_busy[i_issue_rd]));

  assign issue_fire = i_issue_valid && !o_issue_stall &&
                      i_issue_we && (i_issue_rd != '0);

  // Scoreboard next state: clear the retiring write, then let a new set win.
  always_comb begin
    busy_nxt = o_busy;
    if (o_reg_write) begin
      busy_nxt[o_addr_des] = 1'b0;
    end
    if (issue_fire) begin
      busy_nxt[i_issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Write port register stage; x0 writes are swallowed and hold old addr/data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_reg_write <= 1'b0;
      o_addr_des  <= '0;
      o_data      <= '0;
    end else begin
      o_reg_write <= wr_live;
      if (wr_live) begin
        o_addr_des <= sel_addr;
        o_data     <= sel_data;
      end
    end
  end

  // Round-robin pointer: after granting one requester, favour the other.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr <= 1'b0;
    end else if (xfer) begin
      rr_ptr <= gnt0;
    end
  end

  // Busy-register scoreboard.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_busy <= '0;
    end else begin
      o_busy <= busy_nxt;
    end
  end

endmodule
